inst_fetch: RTL and testbench

Instruction-fetch front end that generates the fetch PC, drives the instruction SRAM-like request/response handshake and presents one fetched instruction with its PC to decode. It sits directly upstream of the pipeline's `pcF`/`instrF` inputs. It also absorbs decode stalls and branch/exception redirects, so the datapath never sees a stale or half-fetched instruction.

---
 rtl/inst_fetch.sv | 166 ++++++++++++++++
 tb/tb_inst_fetch.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch front end.
// Generates the fetch PC, runs the SRAM-like req/addr_ok/data_ok handshake
// with at most one request outstanding, and holds one fetched instruction
// (or an AdEL marker for a misaligned PC) for decode. Redirects squash
// anything older: the buffer is cleared and any held or in-flight request
// is marked so that its returning data is dropped.
`timescale 1ns/1ps
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        validF,
    output logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        excF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        discard_q, discard_d;
    // held_q: a request was presented and not yet accepted; it must stay put.
    logic        held_q, held_d;
    // halt_q: the AdEL entry for a misaligned PC was produced; wait for a redirect.
    logic        halt_q, halt_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        exc_q, exc_d;

    logic        buf_room;
    logic        misaligned;
    logic        start;

    // Request outputs: a held request dominates, otherwise start one when the buffer can take its data.
    always_comb begin
        buf_room   = !valid_q || !stallD;
        misaligned = (fetch_pc_q[1:0] != 2'b00);
        start      = (state_q == REQ) && !held_q && !halt_q && !redirect
                     && buf_room && !misaligned;
        inst_req   = held_q || start;
        if (held_q) begin
            inst_addr = req_pc_q;
        end else if (start) begin
            inst_addr = fetch_pc_q;
        end else begin
            inst_addr = 32'h0;
        end
    end

    // Next-state logic: FSM, fetch PC, squash tracking and the output buffer.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        held_d     = held_q;
        halt_d     = halt_q;
        // An entry leaves the buffer on any edge where decode is not stalled.
        valid_d    = valid_q && stallD;
        pc_d       = pc_q;
        instr_d    = instr_q;
        exc_d      = exc_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (inst_req) begin
                    req_pc_d = inst_addr;
                    if (redirect) begin
                        discard_d = 1'b1;
                    end
                    if (inst_addr_ok) begin
                        state_d = WAIT;
                        held_d  = 1'b0;
                        // A request squashed while held leaves fetch_pc at the redirect target.
                        if (!redirect && !discard_q) begin
                            fetch_pc_d = fetch_pc_q + 32'd4;
                        end
                    end else begin
                        held_d = 1'b1;
                    end
                end else if (misaligned && !halt_q && !redirect && buf_room) begin
                    valid_d = 1'b1;
                    pc_d    = fetch_pc_q;
                    instr_d = 32'h0;
                    exc_d   = 1'b1;
                    halt_d  = 1'b1;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    state_d   = REQ;
                    discard_d = 1'b0;
                    if (!discard_q && !redirect) begin
                        valid_d = 1'b1;
                        pc_d    = req_pc_q;
                        instr_d = inst_rdata;
                        exc_d   = 1'b0;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            valid_d    = 1'b0;
            halt_d     = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0;
            discard_q  <= 1'b0;
            held_q     <= 1'b0;
            halt_q     <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= 32'h0;
            instr_q    <= 32'h0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            held_q     <= held_d;
            halt_q     <= halt_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            exc_q      <= exc_d;
        end
    end

    assign validF = valid_q;
    assign pcF    = pc_q;
    assign instrF = instr_q;
    assign excF   = exc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: the bench plays the instruction SRAM and tracks,
// transaction by transaction, which PC decode must see next, which address
// the next fresh request must carry, and whether returning data is live or
// squashed. Directed scenarios pin the model with literal values, then a
// randomized run exercises delays, stalls, redirects and a mid-run reset.
`timescale 1ns/1ps
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallD = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic        validF;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        excF;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stallD(stallD), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .validF(validF), .pcF(pcF), .instrF(instrF),
        .excF(excF)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // stimulus knobs
    logic        drv_stall = 1'b0;
    logic        drv_redir = 1'b0;
    logic [31:0] drv_rpc = 32'h0;
    int          cfg_addr_delay = 0;   // -1 = random 0..3
    int          cfg_data_delay = 1;   // -1 = random 1..3

    // reference model state
    logic        exp_valid, exp_exc, may_exc, halted;
    logic [31:0] exp_pcF, exp_instr, arch_pc, exp_req_addr;
    logic        pend, pend_stale, outst, out_stale;
    logic [31:0] pend_addr, out_addr;
    int          addr_wait, data_wait, idle_cnt;
    logic        last_valid, last_stall, last_redir;

    int          req_cyc[$];
    logic [31:0] req_adr[$];
    int          pres_cyc[$];
    logic [31:0] pres_pc[$];
    logic [31:0] pres_ins[$];
    logic        pres_exc[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic int pick(input int cfg, input int lo, input int hi);
        if (cfg < 0) return int'($urandom_range(hi, lo));
        return cfg;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h required %08h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b required %0b (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        exp_valid = 1'b0; exp_exc = 1'b0; may_exc = 1'b0; halted = 1'b0;
        exp_pcF = 32'h0; exp_instr = 32'h0;
        arch_pc = RESET_PC; exp_req_addr = RESET_PC;
        pend = 1'b0; pend_stale = 1'b0; pend_addr = 32'h0;
        outst = 1'b0; out_stale = 1'b0; out_addr = 32'h0;
        addr_wait = 0; data_wait = 0; idle_cnt = 0;
        last_valid = 1'b0; last_stall = 1'b0; last_redir = 1'b0;
        req_cyc.delete(); req_adr.delete();
        pres_cyc.delete(); pres_pc.delete(); pres_ins.delete(); pres_exc.delete();
        cyc = 0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // request side, play the SRAM, then advance the model across the edge.
    task automatic step();
        logic fresh, consumed, live, stale_now, accept, req_snap;
        @(negedge clk);
        cyc++;
        if (exp_valid) begin
            chk1("validF", validF, 1'b1);
            chk("pcF", pcF, exp_pcF);
            chk("instrF", instrF, exp_instr);
            chk1("excF", excF, exp_exc);
        end else if (may_exc && validF) begin
            chk("adel_pcF", pcF, arch_pc);
            chk("adel_instrF", instrF, 32'h0);
            chk1("adel_excF", excF, 1'b1);
            exp_valid = 1'b1; exp_pcF = arch_pc; exp_instr = 32'h0; exp_exc = 1'b1;
        end else begin
            chk1("validF_empty", validF, 1'b0);
        end
        if (validF) chk("pcF_program_order", pcF, arch_pc);
        if (validF && !(last_valid && last_stall && !last_redir)) begin
            pres_cyc.push_back(cyc); pres_pc.push_back(pcF);
            pres_ins.push_back(instrF); pres_exc.push_back(excF);
        end
        if (validF || halted) idle_cnt = 0;
        else idle_cnt++;
        if (idle_cnt > 60) begin
            checks++; errors++;
            $display("FAIL progress: no instruction for %0d cycles, required at most 60", idle_cnt);
            idle_cnt = 0;
        end

        stallD = drv_stall; redirect = drv_redir; redirect_pc = drv_rpc;
        #1;
        fresh = inst_req && !pend;
        if (pend) begin
            chk1("req_hold", inst_req, 1'b1);
            chk("addr_hold", inst_addr, pend_addr);
        end
        if (outst) chk1("req_while_outstanding", inst_req, 1'b0);
        if (fresh) begin
            chk("req_addr", inst_addr, exp_req_addr);
            chk("req_aligned", {30'h0, inst_addr[1:0]}, 32'h0);
            chk1("req_start_allowed", !redirect && (!validF || !stallD), 1'b1);
            req_cyc.push_back(cyc); req_adr.push_back(inst_addr);
            addr_wait = pick(cfg_addr_delay, 0, 3);
        end

        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = $urandom;
        if (outst) begin
            if (data_wait == 0) begin
                inst_data_ok = 1'b1; inst_rdata = memf(out_addr);
            end else data_wait--;
        end
        if (inst_req) begin
            if (addr_wait == 0) inst_addr_ok = 1'b1;
            else addr_wait--;
        end
        req_snap = inst_req;
        #1;
        if (inst_addr_ok) chk1("req_indep_of_addr_ok", inst_req, req_snap);

        consumed  = exp_valid && !stallD;
        live      = inst_data_ok && outst && !out_stale && !redirect;
        stale_now = (pend && pend_stale) || redirect;
        accept    = inst_req && inst_addr_ok;

        if (redirect) begin
            arch_pc = redirect_pc; halted = 1'b0;
        end else if (consumed) begin
            if (exp_exc) halted = 1'b1;
            else arch_pc = arch_pc + 32'd4;
        end
        if (redirect) exp_valid = 1'b0;
        else if (live) begin
            exp_valid = 1'b1; exp_pcF = out_addr; exp_instr = memf(out_addr); exp_exc = 1'b0;
        end else if (!(exp_valid && stallD)) exp_valid = 1'b0;
        may_exc = !exp_valid && !redirect && !halted && (arch_pc[1:0] != 2'b00);

        if (inst_data_ok) outst = 1'b0;
        else if (outst && redirect) out_stale = 1'b1;
        if (accept) begin
            outst = 1'b1; out_addr = inst_addr; out_stale = stale_now;
            data_wait = pick(cfg_data_delay, 1, 3) - 1;
            if (!stale_now) exp_req_addr = inst_addr + 32'd4;
            pend = 1'b0;
        end else if (inst_req) begin
            pend = 1'b1; pend_addr = inst_addr; pend_stale = stale_now;
        end else pend = 1'b0;
        if (redirect) exp_req_addr = redirect_pc;
        last_valid = validF; last_stall = stallD; last_redir = redirect;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drv_stall = 1'b0; drv_redir = 1'b0; drv_rpc = 32'h0;
        stallD = 1'b0; redirect = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        #1;
        chk1("rst_validF", validF, 1'b0);
        chk("rst_pcF", pcF, 32'h0);
        chk("rst_instrF", instrF, 32'h0);
        chk1("rst_excF", excF, 1'b0);
        chk1("rst_inst_req", inst_req, 1'b0);
        chk("rst_inst_addr", inst_addr, 32'h0);
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        drv_redir = 1'b1; drv_rpc = pc;
        step();
        drv_redir = 1'b0;
    endtask

    task automatic expect_req(input int idx, input logic [31:0] a, input string nm);
        for (int i = 0; i < 40 && req_adr.size() <= idx; i++) step();
        if (req_adr.size() <= idx) begin
            checks++; errors++;
            $display("FAIL %s: no request within 40 cycles, required %08h", nm, a);
        end else chk(nm, req_adr[idx], a);
    endtask

    task automatic expect_pres(input int idx, input logic [31:0] pc, input logic [31:0] ins,
                               input logic exc, input string nm);
        for (int i = 0; i < 40 && pres_pc.size() <= idx; i++) step();
        if (pres_pc.size() <= idx) begin
            checks++; errors++;
            $display("FAIL %s: no instruction within 40 cycles, required pc %08h", nm, pc);
        end else begin
            chk({nm, "_pc"}, pres_pc[idx], pc);
            chk({nm, "_instr"}, pres_ins[idx], ins);
            chk1({nm, "_exc"}, pres_exc[idx], exc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, p0;
        logic [31:0] held_pc;
        model_reset();

        // reset, zero-wait SRAM, no stall
        do_reset();
        cfg_addr_delay = 0; cfg_data_delay = 1;
        repeat (8) step();
        expect_req(0, 32'hBFC0_0000, "zw_req0");
        expect_req(1, 32'hBFC0_0004, "zw_req1");
        expect_req(2, 32'hBFC0_0008, "zw_req2");
        chk_int("zw_req0_cycle", req_cyc[0], 1);
        chk_int("zw_req1_cycle", req_cyc[1], 3);
        expect_pres(0, 32'hBFC0_0000, 32'h403F_FFFF, 1'b0, "zw_pres0");
        expect_pres(1, 32'hBFC0_0004, 32'h403F_FFFB, 1'b0, "zw_pres1");
        chk_int("zw_pres0_cycle", pres_cyc[0], 3);
        chk_int("zw_pres1_cycle", pres_cyc[1], 5);

        // decode stall held 5 cycles on a buffered instruction
        drv_stall = 1'b1;
        for (int i = 0; i < 20 && !validF; i++) step();
        held_pc = pcF;
        n0 = req_adr.size(); p0 = pres_pc.size();
        repeat (5) begin
            step();
            chk("stall_pcF_stable", pcF, held_pc);
        end
        chk_int("stall_no_new_req", req_adr.size(), n0);
        drv_stall = 1'b0;
        expect_pres(p0, held_pc + 32'd4, memf(held_pc + 32'd4), 1'b0, "stall_resume");

        // redirect while waiting for data
        cfg_data_delay = 3;
        for (int i = 0; i < 20 && !(outst && data_wait > 0); i++) step();
        redirect_to(32'h8000_0100);
        n0 = req_adr.size(); p0 = pres_pc.size();
        expect_req(n0, 32'h8000_0100, "wait_redir_req");
        expect_pres(p0, 32'h8000_0100, 32'h7FFF_FEFF, 1'b0, "wait_redir_pres");

        // redirect in the cycle a held request is accepted
        cfg_addr_delay = 2; cfg_data_delay = 1;
        for (int i = 0; i < 20 && !(pend && addr_wait == 0); i++) step();
        redirect_to(32'h8000_0300);
        n0 = req_adr.size(); p0 = pres_pc.size();
        expect_req(n0, 32'h8000_0300, "accept_redir_req");
        expect_pres(p0, 32'h8000_0300, 32'h7FFF_FCFF, 1'b0, "accept_redir_pres");

        // redirect in the cycle live data returns
        cfg_addr_delay = 0; cfg_data_delay = 2;
        for (int i = 0; i < 20 && !(outst && data_wait == 0 && !out_stale); i++) step();
        redirect_to(32'h8000_0400);
        n0 = req_adr.size(); p0 = pres_pc.size();
        expect_req(n0, 32'h8000_0400, "data_redir_req");
        expect_pres(p0, 32'h8000_0400, 32'h7FFF_FBFF, 1'b0, "data_redir_pres");

        // delayed addr_ok with stallD toggling, then PC wrap
        cfg_addr_delay = 3; cfg_data_delay = 1;
        for (int i = 0; i < 20; i++) begin
            drv_stall = ~drv_stall;
            step();
        end
        drv_stall = 1'b0; cfg_addr_delay = 0;
        redirect_to(32'hFFFF_FFFC);
        n0 = req_adr.size(); p0 = pres_pc.size();
        expect_req(n0, 32'hFFFF_FFFC, "wrap_req0");
        expect_req(n0 + 1, 32'h0000_0000, "wrap_req1");
        expect_pres(p0, 32'hFFFF_FFFC, 32'h0000_0003, 1'b0, "wrap_pres0");
        expect_pres(p0 + 1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "wrap_pres1");

        // misaligned redirect target produces an AdEL entry and no request
        redirect_to(32'h8000_0102);
        n0 = req_adr.size(); p0 = pres_pc.size();
        repeat (8) step();
        chk_int("adel_no_req", req_adr.size(), n0);
        expect_pres(p0, 32'h8000_0102, 32'h0, 1'b1, "adel_pres");
        chk1("adel_consumed_once", validF, 1'b0);
        redirect_to(32'h8000_0200);
        n0 = req_adr.size();
        expect_req(n0, 32'h8000_0200, "adel_recover_req");

        // randomized run with a reset in the middle
        cfg_addr_delay = -1; cfg_data_delay = -1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            drv_stall = ($urandom_range(9, 0) < 3);
            drv_redir = ($urandom_range(19, 0) == 0);
            case ($urandom_range(7, 0))
                0: drv_rpc = $urandom;
                1: drv_rpc = 32'hFFFF_FFF8;
                default: drv_rpc = $urandom & 32'hFFFF_FFFC;
            endcase
            step();
        end
        checks++;
        if (pres_pc.size() < 100) begin
            errors++;
            $display("FAIL random_throughput: got %0d instructions, required at least 100", pres_pc.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
